// File: rtl/slow_mem_responder_if.sv
// Cache <-> slow-memory line bus: one 128-bit line per request, completed by a
// single-cycle mem_ready pulse from the responder.
interface slow_mem_responder_if;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         proto_err;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready,
    input  proto_err
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready,
    output proto_err
  );
endinterface

// File: rtl/slow_mem_responder.sv
// Slow line memory responder: accepts one line read/write, waits LATENCY cycles,
// then commits/returns the line and pulses mem_ready for one cycle.
module slow_mem_responder #(
  parameter int unsigned LATENCY    = 8,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  slow_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned LINES    = 1 << DEPTH_LOG2;
  localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    op_write_q, op_write_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [127:0]            wdata_q, wdata_d;
  logic [127:0]            rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    proto_err_q, proto_err_d;
  logic                    mem_we;

  logic [127:0]            mem_array [LINES];

  // Address bits above the line index only alias; they are deliberately dropped.
  generate
    if (DEPTH_LOG2 < 28) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.mem_addr[27:DEPTH_LOG2];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_write_d  = op_write_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    proto_err_d = proto_err_q;
    mem_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          state_d    = BUSY;
          cnt_d      = CNT_LOAD;
          op_write_d = bus.mem_write;
          idx_d      = bus.mem_addr[DEPTH_LOG2-1:0];
          wdata_d    = bus.mem_wdata;
          if (bus.mem_read && bus.mem_write) begin
            proto_err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          ready_d = 1'b1;
          if (op_write_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_array[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_write_q  <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_write_q  <= op_write_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage is not reset; reset forces IDLE, so an aborted write never commits.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_array[idx_q] <= wdata_q;
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ready = ready_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_slow_mem_responder.sv
// Self-checking bench for slow_mem_responder against a line-array reference model.
module tb_slow_mem_responder;

  localparam int unsigned L  = 4;
  localparam int unsigned DL = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  slow_mem_responder_if bus ();

  slow_mem_responder #(.LATENCY(L), .DEPTH_LOG2(DL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [127:0] model_mem [int];
  logic [127:0] last_rdata;
  logic         proto_exp;

  function automatic int line_of(input logic [27:0] a);
    return int'(a) % (1 << DL);
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // Issue a request, hold until mem_ready (bounded), drop it, step to IDLE.
  task automatic txn(input logic rd, input logic wr, input logic [27:0] addr,
                     input logic [127:0] data, output int lat,
                     output logic [127:0] rdata_out, output logic ready_after);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    lat       = -1;
    rdata_out = '0;
    for (int i = 0; i < int'(L) + 20; i++) begin
      tick();
      if (bus.mem_ready === 1'b1) begin
        lat       = i;
        rdata_out = bus.mem_rdata;
        break;
      end
    end
    idle_bus();
    tick();
    ready_after = bus.mem_ready;
  endtask

  task automatic test_reset();
    int lat; logic [127:0] rd; logic ra;
    rst_n = 1'b0;
    idle_bus();
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.mem_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", bus.mem_ready); end
    vectors++;
    if (bus.mem_rdata !== '0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", bus.mem_rdata); end
    vectors++;
    if (bus.proto_err !== 1'b0) begin miscompares++; $display("FAIL reset_proto: got %b want 0", bus.proto_err); end

    // Make outputs non-zero, then assert reset mid-cycle.
    txn(1'b1, 1'b1, 28'h3, 128'h1234_5678, lat, rd, ra);
    model_mem[line_of(28'h3)] = 128'h1234_5678;
    txn(1'b1, 1'b0, 28'h3, '0, lat, rd, ra);
    vectors++;
    if (rd !== 128'h1234_5678) begin miscompares++; $display("FAIL reset_pre_rdata: got %h want %h", rd, 128'h1234_5678); end
    vectors++;
    if (bus.proto_err !== 1'b1) begin miscompares++; $display("FAIL reset_pre_proto: got %b want 1", bus.proto_err); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.mem_rdata !== '0) begin miscompares++; $display("FAIL async_rdata: got %h want 0", bus.mem_rdata); end
    vectors++;
    if (bus.proto_err !== 1'b0) begin miscompares++; $display("FAIL async_proto: got %b want 0", bus.proto_err); end
    vectors++;
    if (bus.mem_ready !== 1'b0) begin miscompares++; $display("FAIL async_ready: got %b want 0", bus.mem_ready); end
    tick();
    rst_n = 1'b1;
    last_rdata = '0;
    proto_exp  = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; logic [127:0] rd; logic ra; logic [127:0] d;
    logic [127:0] pat;
    pat = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
    txn(1'b0, 1'b1, 28'h0000010, pat, lat, rd, ra);
    model_mem[line_of(28'h10)] = pat;
    vectors++;
    if (lat !== int'(L)) begin miscompares++; $display("FAIL wr_latency: got %0d want %0d", lat, L); end
    vectors++;
    if (ra !== 1'b0) begin miscompares++; $display("FAIL wr_pulse_width: got %b want 0", ra); end
    vectors++;
    if (rd !== last_rdata) begin miscompares++; $display("FAIL wr_rdata_kept: got %h want %h", rd, last_rdata); end
    txn(1'b1, 1'b0, 28'h0000010, '0, lat, rd, ra);
    vectors++;
    if (lat !== int'(L)) begin miscompares++; $display("FAIL rd_latency: got %0d want %0d", lat, L); end
    vectors++;
    if (rd !== pat) begin miscompares++; $display("FAIL rd_data: got %h want %h", rd, pat); end
    vectors++;
    if (ra !== 1'b0) begin miscompares++; $display("FAIL rd_pulse_width: got %b want 0", ra); end
    last_rdata = pat;
    // Seed lines 0..7 for later reads.
    for (int i = 0; i < 8; i++) begin
      d = rand_line();
      txn(1'b0, 1'b1, 28'(i), d, lat, rd, ra);
      model_mem[i] = d;
      vectors++;
      if (lat !== int'(L)) begin miscompares++; $display("FAIL seed_latency[%0d]: got %0d want %0d", i, lat, L); end
    end
  endtask

  task automatic test_held_request();
    logic exp;
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b0;
    bus.mem_addr  = 28'h2;
    for (int i = 0; i < 30; i++) begin
      tick();
      exp = (i >= int'(L)) && (((i - int'(L)) % (int'(L) + 2)) == 0);
      vectors++;
      if (bus.mem_ready !== exp) begin miscompares++; $display("FAIL held_ready[%0d]: got %b want %b", i, bus.mem_ready, exp); end
      if (exp) begin
        vectors++;
        if (bus.mem_rdata !== model_mem[2]) begin miscompares++; $display("FAIL held_rdata[%0d]: got %h want %h", i, bus.mem_rdata, model_mem[2]); end
      end
    end
    idle_bus();
    repeat (L + 3) tick();
    last_rdata = model_mem[2];
  endtask

  task automatic test_bus_change();
    int lat; logic [127:0] rd; logic ra;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    bus.mem_addr  = 28'h5;
    bus.mem_wdata = 128'h1;
    tick();
    bus.mem_addr  = 28'h6;
    bus.mem_wdata = 128'h2;
    lat = -1;
    for (int i = 1; i < int'(L) + 20; i++) begin
      tick();
      if (bus.mem_ready === 1'b1) begin lat = i; break; end
    end
    idle_bus();
    tick();
    model_mem[5] = 128'h1;
    vectors++;
    if (lat !== int'(L)) begin miscompares++; $display("FAIL chg_latency: got %0d want %0d", lat, L); end
    txn(1'b1, 1'b0, 28'h5, '0, lat, rd, ra);
    vectors++;
    if (rd !== 128'h1) begin miscompares++; $display("FAIL chg_line5: got %h want 1", rd); end
    txn(1'b1, 1'b0, 28'h6, '0, lat, rd, ra);
    vectors++;
    if (rd !== model_mem[6]) begin miscompares++; $display("FAIL chg_line6: got %h want %h", rd, model_mem[6]); end
    last_rdata = model_mem[6];
  endtask

  task automatic test_proto_err();
    int lat; logic [127:0] rd; logic ra;
    txn(1'b1, 1'b1, 28'h7, 128'hA5, lat, rd, ra);
    model_mem[7] = 128'hA5;
    vectors++;
    if (lat !== int'(L)) begin miscompares++; $display("FAIL perr_latency: got %0d want %0d", lat, L); end
    vectors++;
    if (bus.proto_err !== 1'b1) begin miscompares++; $display("FAIL perr_set: got %b want 1", bus.proto_err); end
    vectors++;
    if (rd !== last_rdata) begin miscompares++; $display("FAIL perr_rdata_kept: got %h want %h", rd, last_rdata); end
    txn(1'b1, 1'b0, 28'h7, '0, lat, rd, ra);
    vectors++;
    if (rd !== 128'hA5) begin miscompares++; $display("FAIL perr_commit: got %h want a5", rd); end
    vectors++;
    if (bus.proto_err !== 1'b1) begin miscompares++; $display("FAIL perr_sticky: got %b want 1", bus.proto_err); end
    last_rdata = 128'hA5;
  endtask

  task automatic test_reset_abort();
    int lat; logic [127:0] rd; logic ra; int seen;
    txn(1'b0, 1'b1, 28'h000, 128'hAA, lat, rd, ra);
    model_mem[0] = 128'hAA;
    vectors++;
    if (lat !== int'(L)) begin miscompares++; $display("FAIL abort_pre_latency: got %0d want %0d", lat, L); end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    bus.mem_addr  = 28'h100;
    bus.mem_wdata = 128'hBB;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    tick();
    idle_bus();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < int'(L) + 4; i++) begin
      tick();
      if (bus.mem_ready !== 1'b0) seen++;
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL abort_no_ready: got %0d pulses want 0", seen); end
    vectors++;
    if (bus.proto_err !== 1'b0) begin miscompares++; $display("FAIL abort_proto_clr: got %b want 0", bus.proto_err); end
    vectors++;
    if (bus.mem_rdata !== '0) begin miscompares++; $display("FAIL abort_rdata_clr: got %h want 0", bus.mem_rdata); end
    txn(1'b1, 1'b0, 28'h000, '0, lat, rd, ra);
    vectors++;
    if (rd !== 128'hAA) begin miscompares++; $display("FAIL abort_alias_read: got %h want aa", rd); end
    last_rdata = 128'hAA;
    proto_exp  = 1'b0;
  endtask

  task automatic test_random();
    int lat; logic [127:0] rd; logic ra;
    logic wr, rdq; logic [27:0] addr; logic [127:0] d; int ln;
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      rdq  = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      addr = (28'($urandom) & ~28'hFF) | 28'($urandom_range(0, 7));
      d    = rand_line();
      ln   = line_of(addr);
      txn(rdq, wr, addr, d, lat, rd, ra);
      proto_exp = proto_exp | (rdq & wr);
      vectors++;
      if (lat !== int'(L)) begin miscompares++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, lat, L); end
      if (wr) begin
        model_mem[ln] = d;
      end else begin
        last_rdata = model_mem[ln];
      end
      vectors++;
      if (rd !== last_rdata) begin miscompares++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, rd, last_rdata); end
      vectors++;
      if (bus.proto_err !== proto_exp) begin miscompares++; $display("FAIL rnd_proto[%0d]: got %b want %b", n, bus.proto_err, proto_exp); end
      vectors++;
      if (ra !== 1'b0) begin miscompares++; $display("FAIL rnd_pulse_width[%0d]: got %b want 0", n, ra); end
    end
  endtask

  initial begin
    last_rdata = '0;
    proto_exp  = 1'b0;
    test_reset();
    test_write_read();
    test_held_request();
    test_bus_change();
    test_proto_err();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
